// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch stage and the decode stage that consumes
// the IF/ID register: instruction width, the canonical NOP, the buffered
// fetch entry type and the base opcode constants used by decode.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 64;

    // addi x0, x0, 0 -- what IF/ID carries whenever it holds no instruction
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    // Major opcodes (instr[6:0]) shared with decode / immediate generation
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Small synchronous in-order FIFO of fetch_entry_t between the instruction
// memory response and the IF/ID register. DEPTH must be a power of two >= 2.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   push/push_data write one entry at the tail
//   pop            retire the head entry (head is valid whenever !empty)
//   clear          discard all entries; wins over a push in the same cycle
//   head           current head entry
//   count          number of entries held (0..DEPTH)
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop together on a full buffer is fine: the head is read before the
    // edge and the freed slot is overwritten at the edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers decide what is live
    always_ff @(posedge clk) begin
        if (push && !clear && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, issues word-aligned requests to
// instruction memory under a credit limit, queues returned words in order and
// drives the IF/ID pipeline register. Supports EX redirect and hazard-unit
// stall/flush. XLEN must not exceed 64.
//
// Optional feature: define FETCH_PERF_CNT_EN to add perf_bubble_cnt and
// perf_redirect_cnt (saturating 32-bit counters).
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request handshake and address
//   imem_resp_valid/data             in-order response words
//   redirect_valid/redirect_pc       taken branch/jump from EX
//   id_stall, id_flush               hazard-unit hold / squash of IF/ID
//   if_id_valid/pc/instr             IF/ID pipeline register
//   perf_bubble_cnt/redirect_cnt     (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               id_stall,
    input  logic               id_flush,
    output logic               if_id_valid,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_bubble_cnt,
    output logic [31:0]        perf_redirect_cnt
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(BUF_DEPTH);

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;

    // PCs of accepted requests, consumed one per response (dropped or not)
    logic [XLEN-1:0]  pcq [BUF_DEPTH];
    logic [PTR_W-1:0] pcq_wr;
    logic [PTR_W-1:0] pcq_rd;

    fetch_entry_t     resp_entry;
    fetch_entry_t     buf_head;
    logic [CNT_W-1:0] buf_count;
    logic             buf_full;
    logic             buf_empty;
    logic             buf_push;
    logic             buf_pop;

    logic issue;
    logic resp_keep;
    logic load;
    logic bypass;

    // Credit rule: in-flight plus buffered words never exceed the buffer, so
    // every response is guaranteed a slot. No request in a redirect cycle.
    always_comb begin
        imem_req_valid = !reset && !redirect_valid &&
                         (({1'b0, outstanding} + {1'b0, buf_count}) < CREDITS);
        imem_req_addr  = pc;
        issue          = imem_req_valid && imem_req_ready;

        resp_keep      = imem_resp_valid && (drop == '0) && !redirect_valid;
        resp_entry.pc    = PC_W'(pcq[pcq_rd]);
        resp_entry.instr = imem_resp_data;

        // A fresh word skips the buffer when IF/ID can take it directly
        load     = !id_flush && !id_stall;
        bypass   = load && buf_empty && resp_keep;
        buf_push = resp_keep && !bypass;
        buf_pop  = load && !buf_empty;
    end

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (buf_push),
        .push_data(resp_entry),
        .pop      (buf_pop),
        .clear    (redirect_valid),
        .head     (buf_head),
        .count    (buf_count),
        .full     (buf_full),
        .empty    (buf_empty)
    );

    // On redirect every request still in flight belongs to the old path;
    // one arriving in the redirect cycle itself is discarded right away.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (issue) begin
                pc <= pc + XLEN'(4);
            end

            case ({issue, imem_resp_valid})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                drop <= imem_resp_valid ? outstanding - CNT_W'(1) : outstanding;
            end else if (imem_resp_valid && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end

            if (issue) begin
                pcq_wr <= pcq_wr + PTR_W'(1);
            end
            if (imem_resp_valid) begin
                pcq_rd <= pcq_rd + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pcq[pcq_wr] <= pc;
        end
    end

    // IF/ID: reset > flush > stall > load (buffer head, else bypass, else bubble)
    always_ff @(posedge clk) begin
        if (reset || id_flush) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (!id_stall) begin
            if (!buf_empty) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= buf_head.pc[XLEN-1:0];
                if_id_instr <= buf_head.instr;
            end else if (resp_keep) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= pcq[pcq_rd];
                if_id_instr <= imem_resp_data;
            end else begin
                if_id_valid <= 1'b0;
                if_id_pc    <= '0;
                if_id_instr <= NOP_INSTR;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters: bubbles loaded on a normal load cycle, redirects
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bubble_cnt   <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (load && buf_empty && !resp_keep && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
            if (redirect_valid && (perf_redirect_cnt != '1)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

    // Protocol violations by the memory side
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_resp_valid && (outstanding == '0)));
            assert (!(buf_push && buf_full && !buf_pop));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. The reference model is the program
// order itself: after reset or a redirect, IF/ID must deliver the sequential
// word stream from the start address with no loss or duplication, and each
// word must be the memory word of its address. A memory model answers
// requests in order with random latency and backpressure.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [63:0] RESET_PC_TB = 64'h1000;
    localparam int          DEPTH_TB    = 2;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_stall;
    logic        id_flush;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int delivered    = 0;
    int ref_bubbles  = 0;
    int ref_redirects = 0;

    logic [63:0] exp_q [$];
    logic [63:0] mq [$];
    logic [63:0] stream_pc;
    logic [63:0] last_acc;
    logic [63:0] req_addr_s;
    logic        req_valid_s;

    bit cyc_reset = 1'b1;
    bit cyc_stall = 1'b0;
    bit cyc_flush = 1'b0;

    logic        cur_valid;
    logic [63:0] cur_pc;
    logic [31:0] cur_instr;

    fetch_stage #(
        .XLEN     (64),
        .RESET_PC (RESET_PC_TB),
        .BUF_DEPTH(DEPTH_TB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .id_stall         (id_stall),
        .id_flush         (id_flush),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_instr      (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubble_cnt  (perf_bubble_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, model memory handshake at posedge
    task automatic applyStimulus(input bit rst, input bit stall, input bit redir,
                                 input logic [63:0] rpc, input bit rdy,
                                 input bit resp_en);
        bit          acc;
        bit          rtaken;
        logic [63:0] acc_addr;
        @(negedge clk);
        reset          = rst;
        id_stall       = stall;
        id_flush       = redir;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        if (resp_en && (mq.size() > 0)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_of(mq[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        cyc_reset = rst;
        cyc_stall = stall;
        cyc_flush = redir;
        if (rst) begin
            exp_q.delete();
            stream_pc     = RESET_PC_TB;
            ref_redirects = 0;
        end else if (redir) begin
            exp_q.delete();
            stream_pc = rpc & ~64'h3;
            ref_redirects++;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(stream_pc);
            stream_pc = stream_pc + 64'd4;
        end
        #1;
        acc         = imem_req_valid && imem_req_ready;
        acc_addr    = imem_req_addr;
        rtaken      = imem_resp_valid;
        req_valid_s = imem_req_valid;
        req_addr_s  = imem_req_addr;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (rtaken) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(acc_addr);
                last_acc = acc_addr;
            end
            checkOutput("outstanding_le_depth", 64'(mq.size() <= DEPTH_TB), 64'd1);
        end
    endtask

    // Monitor: compares IF/ID against the expected program-order stream
    always @(posedge clk) begin
        logic [63:0] e;
        #1;
        if (cyc_reset || cyc_flush) begin
            checkOutput(cyc_reset ? "reset_valid" : "flush_valid", 64'(if_id_valid), 64'd0);
            checkOutput(cyc_reset ? "reset_instr" : "flush_instr", 64'(if_id_instr), 64'(NOP_INSTR));
            if (cyc_reset) begin
                checkOutput("reset_pc", if_id_pc, 64'd0);
                ref_bubbles = 0;
            end
            cur_valid = 1'b0;
            cur_pc    = 64'd0;
            cur_instr = NOP_INSTR;
        end else if (cyc_stall) begin
            checkOutput("stall_hold_valid", 64'(if_id_valid), 64'(cur_valid));
            checkOutput("stall_hold_instr", 64'(if_id_instr), 64'(cur_instr));
            if (cur_valid) checkOutput("stall_hold_pc", if_id_pc, cur_pc);
        end else if (if_id_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_nonempty", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("ifid_pc", if_id_pc, e);
                checkOutput("ifid_instr", 64'(if_id_instr), 64'(word_of(e)));
                delivered++;
                cur_valid = 1'b1;
                cur_pc    = e;
                cur_instr = word_of(e);
            end
        end else begin
            checkOutput("bubble_instr", 64'(if_id_instr), 64'(NOP_INSTR));
            ref_bubbles++;
            cur_valid = 1'b0;
            cur_pc    = 64'd0;
            cur_instr = NOP_INSTR;
        end
    end

    initial begin
        bit          found;
        bit          rst;
        bit          redir;
        int          r;
        logic [63:0] rpc;

        reset = 1'b1; id_stall = 1'b0; id_flush = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 64'h0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0; stream_pc = RESET_PC_TB; last_acc = 64'h0;

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 64'h0, 1, 1);

        // First request accepted right after release, word in IF/ID one cycle later
        applyStimulus(0, 0, 0, 64'h0, 1, 1);
        #2 checkOutput("first_cycle_bubble", 64'(if_id_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 64'h0, 1, 1);
            #2;
            checkOutput("stream_valid", 64'(if_id_valid), 64'd1);
            checkOutput("stream_pc", if_id_pc, RESET_PC_TB + 64'(4 * i));
        end

        // Stall three cycles at 0x1008, then resume at 0x100C
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 64'h0, 1, 1);
            #2 checkOutput("stall_pc_1008", if_id_pc, 64'h1008);
        end
        applyStimulus(0, 0, 0, 64'h0, 1, 1);
        #2 checkOutput("resume_pc_100c", if_id_pc, 64'h100C);

        // Memory refuses requests for five cycles: address must stay put
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 64'h0, 0, 1);
            checkOutput("ready_low_addr", req_addr_s, last_acc + 64'd4);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 64'h0, 1, 1);

        // Redirect to 0x2002 with two requests in flight
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 64'h0, 1, 0);
        checkOutput("outstanding_before_redirect", 64'(mq.size()), 64'd2);
        applyStimulus(0, 0, 1, 64'h2002, 1, 1);
        checkOutput("no_req_in_redirect", 64'(req_valid_s), 64'd0);
        #2 checkOutput("redirect_bubble", 64'(if_id_instr), 64'(NOP_INSTR));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(0, 0, 0, 64'h0, 1, 1);
            #2 found = if_id_valid;
        end
        checkOutput("redirect_first_pc", found ? if_id_pc : 64'hDEAD, 64'h2000);

        // Reset with two requests outstanding
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 64'h0, 1, 0);
        applyStimulus(1, 0, 0, 64'h0, 1, 1);
        checkOutput("no_req_in_reset", 64'(req_valid_s), 64'd0);
        applyStimulus(0, 0, 0, 64'h0, 1, 1);
        checkOutput("post_reset_req_valid", 64'(req_valid_s), 64'd1);
        checkOutput("post_reset_req_addr", req_addr_s, RESET_PC_TB);

        // Randomized traffic, including redirects near the top of the address space
        for (int i = 0; i < 2000; i++) begin
            r     = $urandom_range(0, 999);
            rst   = (r < 5);
            redir = !rst && (r < 45);
            rpc   = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            applyStimulus(rst, $urandom_range(0, 99) < 15, redir, rpc,
                          $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 64'h0, 1, 1);
        #2;

        checkOutput("delivered_min", 64'(delivered >= 200), 64'd1);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_redirect_cnt", 64'(perf_redirect_cnt), 64'(ref_redirects));
        checkOutput("perf_bubble_cnt", 64'(perf_bubble_cnt), 64'(ref_bubbles));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined core. Owns the PC and issues requests to instruction memory.
- Buffers returned instruction words in a small in-order queue and drives the IF/ID pipeline register.
- The decode stage and its immediate generator consume the IF/ID register.
- Supports branch/jump redirect from EX, plus stall and flush from the hazard unit.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- XLEN, 64, PC/address width.
- BUF_DEPTH, 2, instruction-buffer entries (power of two, ≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  fetch address (word aligned).
- imem_resp_valid  input  1  response word valid; responses arrive in request order, ≥1 cycle after acceptance.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  taken branch/jump from EX.
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored.
- id_stall  input  1  hold IF/ID contents.
- id_flush  input  1  squash IF/ID contents to a bubble.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_pc  output  XLEN  PC of the IF/ID instruction.
- if_id_instr  output  32  IF/ID instruction word (NOP when invalid).

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, buffer empty, outstanding=0, drop=0.
  - if_id_valid=0, if_id_pc=0, if_id_instr=32'h00000013.
  - imem_req_valid=0 in the reset cycle.
- Issue:
  - imem_req_valid=1 when outstanding + buf_count < BUF_DEPTH and redirect_valid=0.
  - imem_req_addr=pc. On valid&&ready: pc+=4 (wraps modulo 2^XLEN), outstanding+=1.
- Response:
  - On imem_resp_valid: outstanding-=1.
  - If drop>0: word discarded and drop-=1. Otherwise {pc_of_word, data} is pushed to the buffer tail. A per-entry PC comes from a response-PC queue written at issue.
- Redirect (cycle N):
  - pc=redirect_pc & ~3 and the buffer is cleared.
  - drop = outstanding minus any response arriving in cycle N; that response is also discarded.
  - No request is issued in cycle N. The new target is requested from cycle N+1.
  - IF/ID is not touched by redirect; the hazard unit asserts id_flush alongside it.
- IF/ID priority: reset > id_flush > id_stall > load.
  - Flush: valid=0, instr=NOP, pc=0.
  - Stall: hold.
  - Load: if buffer non-empty, pop head into IF/ID with valid=1; else write a bubble.
- Latency:
  - A request accepted in cycle N with response in cycle N+1 appears in IF/ID at end of cycle N+1 if the buffer was empty; a pushed word is bypassed straight to IF/ID when the buffer is empty and no stall.
  - Steady state is 1 instruction/cycle with single-cycle memory.
- Boundaries:
  - Buffer full: issue blocked by the credit rule. A response never meets a full buffer; if it does, that is an assertion failure.
  - Simultaneous push and pop on a full buffer is legal.
  - Response with outstanding=0 is an assertion failure.
  - Reset mid-transaction discards all in-flight responses. Memory is also reset, so drop is cleared rather than counted.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_bubble_cnt[31:0] and perf_redirect_cnt[31:0].
  - perf_bubble_cnt increments on each cycle a bubble loads into IF/ID without flush or stall.
  - perf_redirect_cnt increments on each redirect_valid.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - constants NOP_INSTR=32'h00000013 and INSTR_W=32;
  - typedef fetch_entry_t {pc, instr}.
  - Opcode constants shared with decode also live here.
- Sub-module fetch_buffer: parametrised synchronous FIFO of fetch_entry_t with push, pop, clear, count, full and empty. clear has priority over push in the same cycle.

Test Plan:
- Reset with RESET_PC=0x1000 and single-cycle memory returning addr-derived words → IF/ID shows pc 0x1000, 0x1004, 0x1008 on consecutive cycles, valid=1, first at cycle 2 after reset release.
- id_stall held 3 cycles at pc 0x1008 → IF/ID holds 0x1008, no more than BUF_DEPTH outstanding+buffered, no word lost; resumes 0x100C.
- redirect_valid+id_flush to 0x2002 with 2 requests outstanding → both stale responses dropped, IF/ID bubble (instr 0x00000013), next valid pc 0x2000.
- imem_req_ready low 5 cycles → imem_req_addr stable, IF/ID bubbles, then fetch resumes in order.
- reset asserted while 2 requests outstanding → all outputs return to reset values next cycle, first fetch at RESET_PC.
- FETCH_PERF_CNT_EN defined: 3 redirects and 4 bubble cycles → perf_redirect_cnt=3, perf_bubble_cnt=4.
